// File: rtl/opsel_if.sv
// Handshake bundle for the ALU operand-select stage: upstream sources/selects in,
// buffered operand pair out.
interface opsel_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 4,
   parameter int SELW    = $clog2(NUM_SRC + 1)
);
   logic [NUM_SRC*WIDTH-1:0] src;
   logic [SELW-1:0]          sel_a;
   logic [SELW-1:0]          sel_b;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         op_a;
   logic [WIDTH-1:0]         op_b;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output src, sel_a, sel_b, in_valid, out_ready,
      input  in_ready, op_a, op_b, out_valid
   );

   modport slave (
      input  src, sel_a, sel_b, in_valid, out_ready,
      output in_ready, op_a, op_b, out_valid
   );
endinterface

// File: rtl/opsel_stage.sv
// Registered operand-select stage with a small output buffer and synchronous flush.
// OPSEL_SKID_EN defined: two-entry buffer with registered in_ready; undefined: single entry.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | no operand pair held, out_valid low
//   ST_ONE   | main register valid, presented to the ALU
//   ST_TWO   | main and skid valid, upstream stalled
module opsel_stage #(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 4,
   parameter int SELW    = $clog2(NUM_SRC + 1)
) (
   input logic   clk,
   input logic   rst_n,
   input logic   flush,
   opsel_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_a_q, main_b_q;
   logic [WIDTH-1:0] skid_a_q, skid_b_q;
   logic [WIDTH-1:0] pick_a, pick_b;
   logic             out_valid, in_ready;
   logic             accept, consume;
   logic             load_main_new, load_main_skid, load_skid;

   // Out-of-range selects fall back to the constants: A gets zero, B gets one.
   always_comb begin
      pick_a = '0;
      pick_b = WIDTH'(1);
      for (int k = 0; k < NUM_SRC; k++) begin
         if (bus.sel_a == SELW'(k)) pick_a = bus.src[k*WIDTH +: WIDTH];
         if (bus.sel_b == SELW'(k)) pick_b = bus.src[k*WIDTH +: WIDTH];
      end
   end

   assign out_valid = (state_q != ST_EMPTY);
`ifdef OPSEL_SKID_EN
   assign in_ready  = (state_q != ST_TWO);
`else
   assign in_ready  = !out_valid || bus.out_ready;
`endif

   assign accept        = bus.in_valid && in_ready;
   assign consume       = out_valid && bus.out_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.op_a      = main_a_q;
   assign bus.op_b      = main_b_q;

   always_comb begin
      state_d        = state_q;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d       = ST_ONE;
               load_main_new = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               load_main_new = 1'b1;
            end else if (accept) begin
`ifdef OPSEL_SKID_EN
               state_d   = ST_TWO;
               load_skid = 1'b1;
`endif
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (consume) begin
               state_d        = ST_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins over everything; a same-cycle consume has already been taken.
      if (flush) begin
         state_d        = ST_EMPTY;
         load_main_new  = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_a_q <= '0;
         main_b_q <= '0;
         skid_a_q <= '0;
         skid_b_q <= '0;
      end else begin
         if (load_main_new) begin
            main_a_q <= pick_a;
            main_b_q <= pick_b;
         end else if (load_main_skid) begin
            main_a_q <= skid_a_q;
            main_b_q <= skid_b_q;
         end
         if (load_skid) begin
            skid_a_q <= pick_a;
            skid_b_q <= pick_b;
         end
      end
   end

endmodule

// File: tb/tb_opsel_stage.sv
// Scoreboard bench for opsel_stage: an 8-bit/4-channel instance for ordering and
// handshake behaviour, and a 16-bit/6-channel instance for the wide select map.
module tb_opsel_stage;

   logic clk = 1'b0;
   logic rst_n;
   logic flush8, flush16;

   always #5 clk = ~clk;

   opsel_if #(.WIDTH(8),  .NUM_SRC(4)) bus8  ();
   opsel_if #(.WIDTH(16), .NUM_SRC(6)) bus16 ();

   opsel_stage #(.WIDTH(8), .NUM_SRC(4)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush8),
      .bus   (bus8)
   );

   opsel_stage #(.WIDTH(16), .NUM_SRC(6)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush16),
      .bus   (bus16)
   );

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
   } pair_t;

   pair_t sb[$];
   pair_t cur_exp;
   int    n_cmp = 0;
   int    n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] pick8(input logic [31:0] s, input logic [2:0] sel, input bit is_b);
      if (sel < 3'd4) return s[sel*8 +: 8];
      return is_b ? 8'h01 : 8'h00;
   endfunction

   task automatic drive8(input logic valid, input logic [31:0] s, input logic [2:0] sa, input logic [2:0] sbs);
      bus8.in_valid = valid;
      bus8.src      = s;
      bus8.sel_a    = sa;
      bus8.sel_b    = sbs;
      cur_exp.a     = pick8(s, sa, 1'b0);
      cur_exp.b     = pick8(s, sbs, 1'b1);
   endtask

   // One clock of the 8-bit instance: check handshake and output before the edge,
   // update the scoreboard for what the edge will do, then step past the edge.
   task automatic cycle8(output bit acc);
      logic exp_rdy, exp_val;
      @(negedge clk);
      exp_val = (sb.size() > 0);
`ifdef OPSEL_SKID_EN
      exp_rdy = (sb.size() < 2);
`else
      exp_rdy = (sb.size() == 0) || bus8.out_ready;
`endif
      chk("in_ready", {31'd0, bus8.in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, bus8.out_valid}, {31'd0, exp_val});
      if (exp_val && bus8.out_ready) begin
         pair_t p;
         p = sb.pop_front();
         chk("op_a", {24'd0, bus8.op_a}, {24'd0, p.a});
         chk("op_b", {24'd0, bus8.op_b}, {24'd0, p.b});
      end
      acc = bus8.in_valid && exp_rdy && !flush8;
      if (flush8) sb.delete();
      else if (acc) sb.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          acc;
      int          n;
      logic [31:0] s;
      logic [95:0] s16;

      rst_n = 1'b0;
      flush8 = 1'b0;
      flush16 = 1'b0;
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      bus8.out_ready = 1'b0;
      bus16.in_valid = 1'b0;
      bus16.src = '0;
      bus16.sel_a = '0;
      bus16.sel_b = '0;
      bus16.out_ready = 1'b1;

      #1;
      chk("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
      chk("rst_op_a", {24'd0, bus8.op_a}, 32'd0);
      chk("rst_op_b", {24'd0, bus8.op_b}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Select map, including constant fallbacks.
      bus8.out_ready = 1'b1;
      drive8(1'b1, 32'h44332211, 3'd2, 3'd4);
      cycle8(acc);
      drive8(1'b1, 32'h44332211, 3'd4, 3'd0);
      cycle8(acc);
      drive8(1'b1, 32'h44332211, 3'd7, 3'd3);
      cycle8(acc);
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      repeat (2) cycle8(acc);

      // Backpressure: stall the ALU until the buffer fills, then release.
      bus8.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive8(1'b1, {24'd0, 8'(8'h10 * (i + 1))}, 3'd0, 3'd0);
         n = 0;
         do begin
            if (n == 3) bus8.out_ready = 1'b1;
            cycle8(acc);
            n++;
         end while (!acc && n < 20);
         chk("bp_accept", {31'd0, acc}, 32'd1);
      end
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      bus8.out_ready = 1'b1;
      repeat (4) cycle8(acc);

      // Streaming at full rate.
      for (int i = 0; i < 16; i++) begin
         s = '0;
         for (int k = 0; k < 4; k++) s[k*8 +: 8] = 8'(i * 4 + k);
         drive8(1'b1, s, 3'(i % 4), 3'((i + 1) % 5));
         cycle8(acc);
      end
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      repeat (3) cycle8(acc);

      // Flush with a concurrent accept while one entry is held.
      bus8.out_ready = 1'b0;
      drive8(1'b1, 32'h0000005A, 3'd0, 3'd0);
      cycle8(acc);
`ifndef OPSEL_SKID_EN
      bus8.out_ready = 1'b1;
`endif
      drive8(1'b1, 32'h000000A5, 3'd0, 3'd0);
      flush8 = 1'b1;
      cycle8(acc);
      flush8 = 1'b0;
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      bus8.out_ready = 1'b0;
      cycle8(acc);
      bus8.out_ready = 1'b1;
      repeat (3) cycle8(acc);

      // Asynchronous reset while the buffer is full.
      bus8.out_ready = 1'b0;
      drive8(1'b1, 32'h00000077, 3'd0, 3'd1);
      cycle8(acc);
      drive8(1'b1, 32'h00000088, 3'd0, 3'd0);
      cycle8(acc);
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
      chk("midrst_op_a", {24'd0, bus8.op_a}, 32'd0);
      chk("midrst_op_b", {24'd0, bus8.op_b}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus8.out_ready = 1'b1;
      drive8(1'b1, 32'h0000C3B2, 3'd1, 3'd0);
      cycle8(acc);
      drive8(1'b0, 32'd0, 3'd0, 3'd0);
      repeat (2) cycle8(acc);

      // Wide instance select map.
      s16 = '0;
      for (int k = 0; k < 6; k++) s16[k*16 +: 16] = 16'(16'h1000 + k * 16'h0111);
      bus16.src = s16;
      bus16.sel_a = 3'd5;
      bus16.sel_b = 3'd6;
      bus16.in_valid = 1'b1;
      @(negedge clk);
      chk("w16_in_ready", {31'd0, bus16.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus16.sel_a = 3'd6;
      bus16.sel_b = 3'd3;
      @(negedge clk);
      chk("w16_valid1", {31'd0, bus16.out_valid}, 32'd1);
      chk("w16_op_a1", {16'd0, bus16.op_a}, 32'h1555);
      chk("w16_op_b1", {16'd0, bus16.op_b}, 32'h0001);
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      @(negedge clk);
      chk("w16_valid2", {31'd0, bus16.out_valid}, 32'd1);
      chk("w16_op_a2", {16'd0, bus16.op_a}, 32'h0000);
      chk("w16_op_b2", {16'd0, bus16.op_b}, 32'h1333);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("w16_drained", {31'd0, bus16.out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/opsel_stage.md
# opsel_stage

Parametrised, registered operand-select stage feeding the ALU in the execute pipeline. Each accepted transaction picks operand A and operand B from NUM_SRC input channels (register file, forwarding paths, immediates) or from fixed constants. The selected pair is captured into a two-entry output buffer with valid/ready handshakes on both sides. A synchronous flush discards in-flight operands on branch redirect.

## Interface
Parameters:
- WIDTH, 8, operand width in bits
- NUM_SRC, 4, number of source channels (≥2)
- SELW, $clog2(NUM_SRC+1), select field width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- src  input  NUM_SRC*WIDTH  flattened channels; channel k at [k*WIDTH +: WIDTH]
- sel_a  input  SELW  operand A select
- sel_b  input  SELW  operand B select
- in_valid  input  1  upstream transaction present
- in_ready  output  1  stage can accept this cycle
- op_a  output  WIDTH  buffered operand A
- op_b  output  WIDTH  buffered operand B
- out_valid  output  1  op_a/op_b valid
- out_ready  input  1  ALU consumes this cycle

Clocking: one clock; reset is asynchronous and active-low.

## Operation
- Select: sel < NUM_SRC → channel sel. sel ≥ NUM_SRC → constant: A gets 0, B gets 1 (WIDTH-bit, zero-extended).
- Accept when in_valid && in_ready; selected pair captured at that edge. src and sel sampled only on accept.
- Buffer states: EMPTY, ONE (main valid), TWO (main + skid valid).
- EMPTY: accept → ONE.
- ONE: accept && !consume → TWO (new data to skid); consume && !accept → EMPTY; both → ONE with new data in main.
- TWO: in_ready = 0; consume → ONE, skid moves to main.
- Consume = out_valid && out_ready.
- in_ready = (state != TWO); registered, not combinationally dependent on out_ready.
- out_valid = (state != EMPTY); op_a/op_b driven from main register.
- Ordering strictly FIFO; no entry ever dropped except by flush/reset.
- flush: next state EMPTY regardless of in_valid/out_ready; a same-cycle accept is discarded; a same-cycle consume still counts as taken by the ALU.
- op_a/op_b hold value while out_valid && !out_ready.

## Timing
- Reset (async assert, any state): state EMPTY, out_valid 0, in_ready 1, op_a 0, op_b 0, skid data 0.
- Release: first accept possible on first rising edge after rst_n high.
- Latency: accept at edge N → out_valid at N (visible cycle N+1 combinationally after edge), i.e. one cycle.
- Throughput: one transaction per cycle with out_ready held high.
- After flush edge: out_valid 0, in_ready 1 next cycle.

## Configuration
- OPSEL_SKID_EN defined: two-entry buffer as above; in_ready registered.
- Not defined: single entry (states EMPTY/ONE only); in_ready = !out_valid || out_ready (combinational); full throughput kept, TWO unreachable, all other rules unchanged.

## Test plan
- Reset mid-TWO: fill both entries, pull rst_n low asynchronously → out_valid 0, op_a/op_b 0, in_ready 1 before next edge.
- Select map, WIDTH=8, NUM_SRC=4: src={0x44,0x33,0x22,0x11}, sel_a=2, sel_b=4 → op_a 0x33, op_b 0x01; sel_a=4, sel_b=0 → op_a 0x00, op_b 0x11.
- Backpressure: out_ready 0, push 3 transactions (0x10,0x20,0x30) → two accepted, in_ready 0 on third; release out_ready → outputs 0x10,0x20,0x30 in order, none lost (skid build).
- Streaming: in_valid and out_ready high 16 cycles, incrementing src → 16 outputs, one per cycle, one-cycle latency.
- Flush with concurrent accept in state ONE: → next cycle out_valid 0, accepted data never appears.
- WIDTH=16, NUM_SRC=6: sel_a=5 → channel 5 value; sel_b=6 → 0x0001.
